// File: rtl/uap_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART probe command engine.
package uap_pkg;

  localparam logic [7:0] UAP_OP_GPO_WR = 8'h01;
  localparam logic [7:0] UAP_OP_GPI_RD = 8'h02;
  localparam logic [7:0] UAP_OP_AXI_WR = 8'h03;
  localparam logic [7:0] UAP_OP_AXI_RD = 8'h04;

  localparam logic [7:0] UAP_RSP_ACK     = 8'h01;
  localparam logic [7:0] UAP_RSP_BADOP   = 8'hEE;
  localparam logic [7:0] UAP_RSP_TIMEOUT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_EXEC,
    ST_AW_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RESP
  } uap_state_e;

  function automatic int uap_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uap_resp_buf.sv
// Response shift buffer: parallel-loads up to NBYTES bytes (MSB-first, left-aligned)
// and drains them one byte per tx handshake.
module uap_resp_buf #(
  parameter int NBYTES = 5,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   load_data,
  input  logic [CW-1:0]         load_cnt,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  last_done
);

  logic [8*NBYTES-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fire;

  assign fire      = tx_valid && tx_ready;
  assign tx_data   = shift_q[8*NBYTES-1 -: 8];
  assign tx_valid  = (cnt_q != '0);
  assign last_done = fire && (cnt_q == CW'(1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = load_cnt;
    end else if (fire) begin
      shift_d = {shift_q[8*NBYTES-9:0], 8'h00};
      cnt_d   = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uap_cmd_engine.sv
// UART probe command engine: decodes rx bytes into GPO/GPI and single-beat AXI accesses.
// Optional AXI response timeout is built when UAP_TIMEOUT_EN is defined.
module uap_cmd_engine
  import uap_pkg::*;
#(
  parameter int               GPO_W     = 32,
  parameter int               GPI_W     = 32,
  parameter logic [GPO_W-1:0] GPO_RESET = '0,
  parameter int               AXI_AW    = 32,
  parameter int               AXI_DW    = 32,
  parameter int               TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [GPO_W-1:0]      gpo,
  input  logic [GPI_W-1:0]      gpi,
  output logic [AXI_AW-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [2:0]            m_axi_awsize,
  output logic [AXI_DW-1:0]     m_axi_wdata,
  output logic [AXI_DW/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [AXI_AW-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arsize,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_DW-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int GB    = GPO_W / 8;
  localparam int IB    = GPI_W / 8;
  localparam int AB    = AXI_AW / 8;
  localparam int DB    = AXI_DW / 8;
  localparam int BUF_N = 1 + uap_max(IB, DB);
  localparam int BUF_W = 8 * BUF_N;
  localparam int CW    = $clog2(BUF_N + 1);
  localparam int ARG_W = 8 * uap_max(GB, AB + DB + 1);

  uap_state_e              state_q, state_d;
  logic [7:0]              op_q, op_d;
  logic [7:0]              nargs_q, nargs_d;
  logic [7:0]              arg_cnt_q, arg_cnt_d;
  logic [ARG_W-1:0]        arg_q, arg_d;
  logic [GPO_W-1:0]        gpo_q, gpo_d;
  logic [AXI_AW-1:0]       awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXI_DW-1:0]       wdata_q, wdata_d;
  logic [AXI_DW/8-1:0]     wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    rdy_en_q;

  logic                    rx_fire, aw_fire, w_fire;
  logic [7:0]              nargs_new;
  logic                    rb_load, rb_last;
  logic [BUF_W-1:0]        rb_data;
  logic [CW-1:0]           rb_cnt;
  logic                    tmo_hit;

  // rx_ready stays low until the first clock after reset release
  assign rx_ready      = rdy_en_q && (state_q == ST_IDLE || state_q == ST_ARGS);
  assign rx_fire       = rx_valid && rx_ready;
  assign m_axi_awvalid = (state_q == ST_AW_W) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == ST_AW_W) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_B);
  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_rready  = (state_q == ST_R);
  assign aw_fire       = m_axi_awvalid && m_axi_awready;
  assign w_fire        = m_axi_wvalid && m_axi_wready;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_awsize  = 3'($clog2(DB));
  assign m_axi_arsize  = 3'($clog2(DB));
  assign gpo           = gpo_q;

  always_comb begin
    nargs_new = 8'd0;
    case (rx_data)
      UAP_OP_GPO_WR: nargs_new = 8'(GB);
      UAP_OP_AXI_WR: nargs_new = 8'(AB + DB + 1);
      UAP_OP_AXI_RD: nargs_new = 8'(AB);
      default:       nargs_new = 8'd0;
    endcase
  end

`ifdef UAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  // counts only while staying in B or R; any transition restarts from zero
  assign tmo_d   = ((state_q == ST_B || state_q == ST_R) && state_d == state_q)
                   ? tmo_q + TW'(1) : '0;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    nargs_d   = nargs_q;
    arg_cnt_d = arg_cnt_q;
    arg_d     = arg_q;
    gpo_d     = gpo_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rb_load   = 1'b0;
    rb_data   = '0;
    rb_cnt    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          op_d      = rx_data;
          nargs_d   = nargs_new;
          arg_cnt_d = 8'd0;
          state_d   = (nargs_new != 8'd0) ? ST_ARGS : ST_EXEC;
        end
      end
      ST_ARGS: begin
        if (rx_fire) begin
          arg_d     = {arg_q[ARG_W-9:0], rx_data};
          arg_cnt_d = arg_cnt_q + 8'd1;
          if (arg_cnt_q + 8'd1 == nargs_q) state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          UAP_OP_GPO_WR: begin
            gpo_d                 = arg_q[GPO_W-1:0];
            rb_load               = 1'b1;
            rb_data[BUF_W-1 -: 8] = UAP_RSP_ACK;
            rb_cnt                = CW'(1);
            state_d               = ST_RESP;
          end
          UAP_OP_GPI_RD: begin
            rb_load                   = 1'b1;
            rb_data[BUF_W-1 -: GPI_W] = gpi;
            rb_cnt                    = CW'(IB);
            state_d                   = ST_RESP;
          end
          UAP_OP_AXI_WR: begin
            // arg layout after shifting: {addr, data, strobe byte}
            awaddr_d  = arg_q[8+AXI_DW +: AXI_AW];
            wdata_d   = arg_q[8 +: AXI_DW];
            wstrb_d   = arg_q[DB-1:0];
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_AW_W;
          end
          UAP_OP_AXI_RD: begin
            araddr_d = arg_q[AXI_AW-1:0];
            state_d  = ST_AR;
          end
          default: begin
            rb_load               = 1'b1;
            rb_data[BUF_W-1 -: 8] = UAP_RSP_BADOP;
            rb_cnt                = CW'(1);
            state_d               = ST_RESP;
          end
        endcase
      end
      ST_AW_W: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_B;
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          rb_load               = 1'b1;
          rb_data[BUF_W-1 -: 8] = {6'b0, m_axi_bresp};
          rb_cnt                = CW'(1);
          state_d               = ST_RESP;
        end else if (tmo_hit) begin
          rb_load               = 1'b1;
          rb_data[BUF_W-1 -: 8] = UAP_RSP_TIMEOUT;
          rb_cnt                = CW'(1);
          state_d               = ST_RESP;
        end
      end
      ST_AR: begin
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        if (m_axi_rvalid) begin
          rb_load                        = 1'b1;
          rb_data[BUF_W-1 -: 8+AXI_DW]   = {6'b0, m_axi_rresp, m_axi_rdata};
          rb_cnt                         = CW'(1 + DB);
          state_d                        = ST_RESP;
        end else if (tmo_hit) begin
          rb_load               = 1'b1;
          rb_data[BUF_W-1 -: 8] = UAP_RSP_TIMEOUT;
          rb_cnt                = CW'(1);
          state_d               = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rb_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      nargs_q   <= '0;
      arg_cnt_q <= '0;
      arg_q     <= '0;
      gpo_q     <= GPO_RESET;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      nargs_q   <= nargs_d;
      arg_cnt_q <= arg_cnt_d;
      arg_q     <= arg_d;
      gpo_q     <= gpo_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdy_en_q  <= 1'b1;
    end
  end

  uap_resp_buf #(
    .NBYTES (BUF_N),
    .CW     (CW)
  ) u_resp_buf (
    .clk       (clk),
    .aresetn   (aresetn),
    .load      (rb_load),
    .load_data (rb_data),
    .load_cnt  (rb_cnt),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .last_done (rb_last)
  );

  logic unused_in;
  assign unused_in = m_axi_rlast;

endmodule

// File: tb/tb_uap_cmd_engine.sv
// Directed bench for uap_cmd_engine with a tx-byte scoreboard queue.
module tb_uap_cmd_engine;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpo;
  logic [31:0] gpi;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [2:0]  awsize;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;
  logic        slow_mode = 1'b0;
  int          hold_cnt = 0;
  int          aw_hs = 0;
  int          w_hs = 0;
  logic [31:0] cap_awaddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_wlast = 1'b0;

  always #5 clk = ~clk;

  uap_cmd_engine #(
    .GPO_W   (32),
    .GPI_W   (32),
    .AXI_AW  (32),
    .AXI_DW  (32),
    .TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .gpo           (gpo),
    .gpi           (gpi),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_awsize  (awsize),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arsize  (arsize),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  // tx sink: in slow mode each byte is held off for three cycles
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (slow_mode && tx_valid && hold_cnt < 3) begin
        tx_ready = 1'b0;
        hold_cnt++;
      end else begin
        tx_ready = 1'b1;
        hold_cnt = 0;
      end
    end
  end

  // Output monitor: tx scoreboard, tx hold stability, AXI handshake capture
  always @(negedge clk) begin
    if (aresetn) begin
      if (hold_prev) begin
        n_cmp++;
        assert ({tx_valid, tx_data} === {1'b1, data_prev}) else begin
          n_fail++;
          $error("FAIL tx_hold observed=%0b/%02h expected=1/%02h", tx_valid, tx_data, data_prev);
        end
      end
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $error("FAIL tx_unexpected observed=%02h expected=none", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          assert (tx_data === exp_b) else begin
            n_fail++;
            $error("FAIL tx_byte observed=%02h expected=%02h", tx_data, exp_b);
          end
          $display("tx byte %02h (expected %02h)", tx_data, exp_b);
        end
      end
      hold_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
      if (awvalid && awready) begin
        aw_hs++;
        cap_awaddr = awaddr;
      end
      if (wvalid && wready) begin
        w_hs++;
        cap_wdata = wdata;
        cap_wstrb = wstrb;
        cap_wlast = wlast;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $error("FAIL rx_accept observed=stalled expected=accept byte %02h", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
    $display("cmd sent: opcode %02h, %0d bytes", bytes[0], bytes.size());
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [7:0] cmd[$];
    aresetn  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    gpi      = 32'h1234_5678;
    awready  = 1'b0;
    wready   = 1'b0;
    bresp    = 2'b00;
    bvalid   = 1'b0;
    arready  = 1'b0;
    rdata    = '0;
    rresp    = 2'b00;
    rlast    = 1'b0;
    rvalid   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gpo", 64'(gpo), 64'h0);
    check("rst_rx_ready", 64'(rx_ready), 64'h0);
    check("rst_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
    check("rst_addr_data", 64'({awaddr, araddr} | {wdata, 28'h0, wstrb}), 64'h0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // GPO write
    exp_q.push_back(8'h01);
    cmd = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_cmd(cmd);
    wait_done("gpo_wr");
    check("gpo_value", 64'(gpo), 64'hDEAD_BEEF);

    // GPI read with tx back-pressure
    slow_mode = 1'b1;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    cmd = '{8'h02};
    send_cmd(cmd);
    wait_done("gpi_rd");
    slow_mode = 1'b0;

    // AXI write, AW completes 4 cycles after W
    exp_q.push_back(8'h00);
    cmd = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0F};
    send_cmd(cmd);
    n = 0;
    while (!wvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("wr_wvalid", 64'(wvalid), 64'h1);
    check("wr_awvalid_together", 64'(awvalid), 64'h1);
    wready = 1'b1;
    @(posedge clk); #1;
    wready = 1'b0;
    check("wr_wvalid_dropped", 64'(wvalid), 64'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("wr_awvalid_held", 64'(awvalid), 64'h1);
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    check("wr_awvalid_dropped", 64'(awvalid), 64'h0);
    check("wr_bready", 64'(bready), 64'h1);
    bvalid = 1'b1;
    bresp  = 2'b00;
    @(posedge clk); #1;
    bvalid = 1'b0;
    check("wr_bready_dropped", 64'(bready), 64'h0);
    wait_done("axi_wr");
    check("wr_aw_count", 64'(aw_hs), 64'd1);
    check("wr_w_count", 64'(w_hs), 64'd1);
    check("wr_awaddr", 64'(cap_awaddr), 64'h0000_1000);
    check("wr_wdata", 64'(cap_wdata), 64'hCAFE_F00D);
    check("wr_wstrb", 64'(cap_wstrb), 64'hF);
    check("wr_wlast", 64'(cap_wlast), 64'h1);
    check("wr_awsize", 64'(awsize), 64'd2);

    // AXI read with SLVERR
    exp_q.push_back(8'h02); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    cmd = '{8'h04, 8'h00, 8'h00, 8'h20, 8'h00};
    send_cmd(cmd);
    n = 0;
    while (!arvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("rd_arvalid", 64'(arvalid), 64'h1);
    check("rd_araddr", 64'(araddr), 64'h0000_2000);
    check("rd_arsize", 64'(arsize), 64'd2);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    check("rd_arvalid_dropped", 64'(arvalid), 64'h0);
    check("rd_rready", 64'(rready), 64'h1);
    rvalid = 1'b1;
    rdata  = 32'hA5A5_5A5A;
    rresp  = 2'b10;
    rlast  = 1'b1;
    @(posedge clk); #1;
    rvalid = 1'b0;
    rlast  = 1'b0;
    wait_done("axi_rd");

    // Unknown opcode followed immediately by GPI read
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    cmd = '{8'h7E, 8'h02};
    send_cmd(cmd);
    wait_done("badop_then_gpi");

`ifdef UAP_TIMEOUT_EN
    // Read with no rvalid: timeout reply after 16 cycles in R
    exp_q.push_back(8'hFF);
    cmd = '{8'h04, 8'h00, 8'h00, 8'h30, 8'h00};
    send_cmd(cmd);
    n = 0;
    while (!arvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("tmo_arvalid", 64'(arvalid), 64'h1);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("tmo_cycles", 64'(n), 64'd16);
    check("tmo_rready_dropped", 64'(rready), 64'h0);
    wait_done("timeout");
`endif

    // Asynchronous reset in the middle of AW_W
    cmd = '{8'h03, 8'h00, 8'h00, 8'h40, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h0F};
    send_cmd(cmd);
    n = 0;
    while (!wvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("awreset_in_aw_w", 64'({awvalid, wvalid}), 64'h3);
    #2;
    aresetn = 1'b0;
    #1;
    check("awreset_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'h0);
    check("awreset_gpo", 64'(gpo), 64'h0);
    check("awreset_addr_data", 64'({awaddr, wdata}), 64'h0);
    check("awreset_wstrb", 64'(wstrb), 64'h0);
    check("awreset_rx_tx", 64'({rx_ready, tx_valid}), 64'h0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("awreset_no_resp", 64'(tx_valid), 64'h0);
    check("awreset_no_aw_hs", 64'(aw_hs), 64'd1);

    // Engine recovers after reset
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    cmd = '{8'h02};
    send_cmd(cmd);
    wait_done("post_reset_gpi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
